mem_port_arbiter: RTL and testbench

Single-port memory arbiter and pipeline freeze controller for the five-stage core. It shares one fixed-latency SRAM port between the fetch stage (instruction reads) and the memory stage (data reads/writes). While any access is outstanding it holds the pipeline with a freeze signal, and it returns read data through held result registers. It sits between stage1/stage4 and the external SRAM, and its freeze output drives the PC enable and all pipeline registers.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency SRAM port between instruction fetch and data access, with data given priority.
// Latency: a single access takes WAIT_CYCLES+1 cycles from request to ready; back-to-back accesses have a one-cycle IDLE bubble.
// Backpressure: freeze stays high while any request is pending; inputs are ignored while an access is in flight.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              freeze,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA_ACC = 2'd1,
        INST_ACC = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              d_done;
    logic              i_done;
    logic [DATA_W-1:0] mem_rdata_q;
    logic [DATA_W-1:0] if_rdata_q;

    logic mem_req;
    logic pend_d;
    logic pend_i;
    logic acc_last;
    logic set_d;
    logic set_i;

    // Pending terms: a request whose result has already been delivered is not pending.
    assign mem_req = mem_r_en | mem_w_en;
    assign pend_d  = mem_req & ~d_done;
    assign pend_i  = if_req & ~i_done;
    assign freeze  = pend_d | pend_i;

    assign acc_last = (state != IDLE) && (cnt == LAST_CNT);

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign if_rdata   = if_rdata_q;
    assign mem_ready  = d_done;
    assign if_ready   = i_done;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: data wins over fetch because the memory stage holds the older instruction.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pend_d) begin
                    state_nxt = DATA_ACC;
                end else if (pend_i) begin
                    state_nxt = INST_ACC;
                end
            end
            DATA_ACC, INST_ACC: begin
                if (acc_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs: SRAM strobes and completion pulses.
    always_comb begin
        sram_en = 1'b0;
        sram_we = 1'b0;
        set_d   = 1'b0;
        set_i   = 1'b0;
        case (state)
            DATA_ACC: begin
                sram_en = 1'b1;
                sram_we = we_q;
                set_d   = acc_last;
            end
            INST_ACC: begin
                sram_en = 1'b1;
                set_i   = acc_last;
            end
            default: begin
                sram_en = 1'b0;
            end
        endcase
    end

    // Wait counter: counts access cycles, parked at zero outside an access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (state == IDLE || acc_last) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    // Request latches: captured only when an access is launched from IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (state == IDLE) begin
            if (pend_d) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                we_q    <= mem_w_en;
            end else if (pend_i) begin
                addr_q <= if_addr;
                we_q   <= 1'b0;
            end
        end
    end

    // Done flags: set on completion, cleared on any edge where the pipeline advances; set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_done <= 1'b0;
            i_done <= 1'b0;
        end else begin
            if (set_d) begin
                d_done <= 1'b1;
            end else if (!freeze) begin
                d_done <= 1'b0;
            end
            if (set_i) begin
                i_done <= 1'b1;
            end else if (!freeze) begin
                i_done <= 1'b0;
            end
        end
    end

    // Held result registers: loads and fetches capture SRAM data in the last access cycle; stores leave mem_rdata alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rdata_q <= '0;
            if_rdata_q  <= '0;
        end else begin
            if (set_d && !we_q) begin
                mem_rdata_q <= sram_rdata;
            end
            if (set_i) begin
                if_rdata_q <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a countdown-based reference model checked every cycle.
// Latency: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: the bench behaves like the pipeline, holding requests while freeze is high.
module tb_mem_port_arbiter;

    localparam int W  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          mem_r_en;
    logic          mem_w_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          freeze;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .WAIT_CYCLES(W),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .freeze    (freeze),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Reference model: which access is in flight (0 none, 1 data, 2 fetch) and how many SRAM cycles remain.
    int            m_kind;
    int            m_left;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;
    logic          m_dd;
    logic          m_id;
    logic [DW-1:0] m_mrd;
    logic [DW-1:0] m_ird;

    function automatic logic exp_freeze();
        return ((mem_r_en | mem_w_en) & ~m_dd) | (if_req & ~m_id);
    endfunction

    // Model update on each edge, mirroring the arbiter's external contract.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_kind  = 0;
            m_left  = 0;
            m_addr  = '0;
            m_wdata = '0;
            m_we    = 1'b0;
            m_dd    = 1'b0;
            m_id    = 1'b0;
            m_mrd   = '0;
            m_ird   = '0;
        end else begin
            logic f;
            logic done_d;
            logic done_i;
            f      = exp_freeze();
            done_d = 1'b0;
            done_i = 1'b0;
            if (m_kind != 0) begin
                if (m_left == 1) begin
                    if (m_kind == 1) begin
                        done_d = 1'b1;
                        if (!m_we) m_mrd = sram_rdata;
                    end else begin
                        done_i = 1'b1;
                        m_ird  = sram_rdata;
                    end
                    m_kind = 0;
                    m_left = 0;
                end else begin
                    m_left = m_left - 1;
                end
            end else if ((mem_r_en | mem_w_en) && !m_dd) begin
                m_kind  = 1;
                m_left  = W;
                m_addr  = mem_addr;
                m_wdata = mem_wdata;
                m_we    = mem_w_en;
            end else if (if_req && !m_id) begin
                m_kind = 2;
                m_left = W;
                m_addr = if_addr;
                m_we   = 1'b0;
            end
            if (!f) begin
                m_dd = 1'b0;
                m_id = 1'b0;
            end
            if (done_d) m_dd = 1'b1;
            if (done_i) m_id = 1'b1;
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        chk("m_freeze", freeze, exp_freeze());
        chk("m_sram_en", sram_en, m_kind != 0);
        chk("m_sram_we", sram_we, (m_kind == 1) && m_we);
        if (m_kind != 0) chk("m_sram_addr", sram_addr, m_addr);
        if (m_kind == 1 && m_we) chk("m_sram_wdata", sram_wdata, m_wdata);
        chk("m_mem_ready", mem_ready, m_dd);
        chk("m_if_ready", if_ready, m_id);
        chk("m_mem_rdata", mem_rdata, m_mrd);
        chk("m_if_rdata", if_rdata, m_ird);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before t=100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        sram_rdata = '0;
        #1 rst = 1'b0;

        // Reset with no requests: everything zero.
        mid();
        chk("rst_freeze", freeze, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);

        // Fetch request held during reset: freeze follows its equation, SRAM stays idle.
        if_req     = 1'b1;
        if_addr    = 32'h10;
        sram_rdata = 32'hE3A00001;
        #1;
        chk("rst_req_freeze", freeze, 1);
        chk("rst_req_sram_en", sram_en, 0);

        // Fetch only: release reset, this is cycle 0.
        tick(); rst = 1'b1;
        mid();
        chk("f0_freeze", freeze, 1);
        chk("f0_sram_en", sram_en, 0);
        for (int c = 1; c <= 2; c++) begin
            tick(); mid();
            chk("f_acc_sram_en", sram_en, 1);
            chk("f_acc_sram_we", sram_we, 0);
            chk("f_acc_sram_addr", sram_addr, 32'h10);
            chk("f_acc_freeze", freeze, 1);
        end
        tick(); mid();
        chk("f3_if_ready", if_ready, 1);
        chk("f3_if_rdata", if_rdata, 32'hE3A00001);
        chk("f3_freeze", freeze, 0);
        chk("f3_sram_en", sram_en, 0);
        tick(); if_req = 1'b0;
        mid();
        chk("f4_if_ready", if_ready, 0);
        chk("f4_freeze", freeze, 0);
        chk("f4_if_rdata_held", if_rdata, 32'hE3A00001);

        // Store and fetch together: store first, one bubble, then fetch.
        tick();
        mem_w_en   = 1'b1;
        mem_addr   = 32'h400;
        mem_wdata  = 32'h55;
        if_req     = 1'b1;
        if_addr    = 32'h14;
        sram_rdata = 32'h12345678;
        mid();
        chk("sf0_freeze", freeze, 1);
        chk("sf0_sram_en", sram_en, 0);
        for (int c = 1; c <= 2; c++) begin
            tick(); mid();
            chk("sf_st_sram_en", sram_en, 1);
            chk("sf_st_sram_we", sram_we, 1);
            chk("sf_st_sram_addr", sram_addr, 32'h400);
            chk("sf_st_sram_wdata", sram_wdata, 32'h55);
        end
        tick(); mid();
        chk("sf3_sram_en", sram_en, 0);
        chk("sf3_mem_ready", mem_ready, 1);
        chk("sf3_freeze", freeze, 1);
        for (int c = 4; c <= 5; c++) begin
            tick(); mid();
            chk("sf_if_sram_en", sram_en, 1);
            chk("sf_if_sram_we", sram_we, 0);
            chk("sf_if_sram_addr", sram_addr, 32'h14);
            chk("sf_if_mem_ready", mem_ready, 1);
            chk("sf_if_freeze", freeze, 1);
        end
        tick(); mid();
        chk("sf6_freeze", freeze, 0);
        chk("sf6_mem_ready", mem_ready, 1);
        chk("sf6_if_ready", if_ready, 1);
        chk("sf6_if_rdata", if_rdata, 32'h12345678);
        chk("sf6_mem_rdata_unchanged", mem_rdata, 0);
        tick(); mem_w_en = 1'b0; if_req = 1'b0;
        mid();
        chk("sf7_mem_ready", mem_ready, 0);
        chk("sf7_if_ready", if_ready, 0);

        // Load with an address change mid-access: latched address must stay on the SRAM.
        tick();
        mem_r_en   = 1'b1;
        mem_addr   = 32'h404;
        sram_rdata = 32'hDEADBEEF;
        mid();
        chk("ld0_freeze", freeze, 1);
        tick(); mid();
        chk("ld1_sram_en", sram_en, 1);
        chk("ld1_sram_addr", sram_addr, 32'h404);
        chk("ld1_sram_we", sram_we, 0);
        tick(); mem_addr = 32'h800;
        mid();
        chk("ld2_sram_addr", sram_addr, 32'h404);
        tick(); mid();
        chk("ld3_mem_ready", mem_ready, 1);
        chk("ld3_mem_rdata", mem_rdata, 32'hDEADBEEF);
        chk("ld3_freeze", freeze, 0);
        tick(); mem_r_en = 1'b0; mem_addr = '0;
        mid();
        chk("ld4_mem_ready", mem_ready, 0);
        chk("ld4_mem_rdata_held", mem_rdata, 32'hDEADBEEF);

        // Reset in the second DATA_ACC cycle, then restart after release.
        tick();
        mem_r_en   = 1'b1;
        mem_addr   = 32'h500;
        sram_rdata = 32'hCAFEF00D;
        mid();
        chk("ra0_freeze", freeze, 1);
        tick(); mid();
        chk("ra1_sram_en", sram_en, 1);
        tick(); rst = 1'b0;
        #1;
        chk("ra2_sram_en", sram_en, 0);
        chk("ra2_mem_ready", mem_ready, 0);
        chk("ra2_freeze", freeze, 1);
        chk("ra2_mem_rdata", mem_rdata, 0);
        tick(); rst = 1'b1;
        mid();
        chk("rb0_sram_en", sram_en, 0);
        chk("rb0_freeze", freeze, 1);
        for (int c = 1; c <= 2; c++) begin
            tick(); mid();
            chk("rb_sram_en", sram_en, 1);
            chk("rb_sram_addr", sram_addr, 32'h500);
        end
        tick(); mid();
        chk("rb3_mem_ready", mem_ready, 1);
        chk("rb3_mem_rdata", mem_rdata, 32'hCAFEF00D);
        chk("rb3_freeze", freeze, 0);

        // Back-to-back load: request held into the next instruction, one IDLE bubble.
        tick(); mem_addr = 32'h600; sram_rdata = 32'h0BADCAFE;
        mid();
        chk("bb0_sram_en", sram_en, 0);
        chk("bb0_freeze", freeze, 1);
        chk("bb0_mem_ready", mem_ready, 0);
        tick(); mid();
        chk("bb1_sram_en", sram_en, 1);
        chk("bb1_sram_addr", sram_addr, 32'h600);
        tick(); mid();
        tick(); mid();
        chk("bb3_mem_ready", mem_ready, 1);
        chk("bb3_mem_rdata", mem_rdata, 32'h0BADCAFE);
        tick(); mem_r_en = 1'b0;
        mid();
        chk("bb4_freeze", freeze, 0);
        tick(); mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
